// File: rtl/regfile_bypass_param.sv
// rtl/regfile_bypass_param.sv - parametrised register file with write-to-read bypass and clear sweep
module regfile_bypass_param #(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 8,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read1RegSel,
  input  logic [ADDR_W-1:0] read2RegSel,
  input  logic [ADDR_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              writeEn,
  input  logic              clrReq,
  output logic [WIDTH-1:0]  read1Data,
  output logic [WIDTH-1:0]  read2Data,
  output logic              busy,
  output logic              clrDone,
  output logic              err
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              clr_done_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic sweep_en;
  logic last_step;
  logic wr_fire;
  logic wr_store;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_done_q <= last_step;
      ptr_q      <= sweep_en ? ptr_q + ADDR_W'(1) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clrReq) state_d = SWEEP;
      SWEEP:   if (ptr_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A sweep owns the storage: writes are blocked and do not bypass either.
  always_comb begin
    sweep_en  = (state_q == SWEEP);
    last_step = sweep_en && (ptr_q == LAST);
    wr_fire   = writeEn && !sweep_en;
    wr_store  = wr_fire && !((ZERO_REG != 0) && (writeRegSel == '0));
  end

  assign busy    = (state_q == SWEEP);
  assign clrDone = clr_done_q;
  assign err     = $isunknown({writeEn, writeData}) || (writeEn && busy);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (sweep_en) begin
      mem[ptr_q] <= '0;
    end else if (wr_store) begin
      mem[writeRegSel] <= writeData;
    end
  end

  // Later assignments take priority: zero register over bypass over storage.
  always_comb begin
    read1Data = mem[read1RegSel];
    if (wr_fire && (read1RegSel == writeRegSel)) read1Data = writeData;
    if ((ZERO_REG != 0) && (read1RegSel == '0)) read1Data = '0;

    read2Data = mem[read2RegSel];
    if (wr_fire && (read2RegSel == writeRegSel)) read2Data = writeData;
    if ((ZERO_REG != 0) && (read2RegSel == '0)) read2Data = '0;
  end

endmodule

// File: tb/tb_regfile_bypass_param.sv
// tb/tb_regfile_bypass_param.sv - scoreboard bench for regfile_bypass_param
module tb_regfile_bypass_param;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int Z  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] r1_sel = '0, r2_sel = '0, w_sel = '0;
  logic [W-1:0]  w_data = '0;
  logic          w_en = 1'b0, clr_req = 1'b0;
  logic [W-1:0]  r1_data, r2_data;
  logic          busy, clr_done, err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic         busy;
    logic         done;
    logic         err;
    int           idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: register array plus a count of registers left to clear.
  logic [W-1:0] m_reg [D];
  int           m_left;
  bit           m_done;

  regfile_bypass_param #(.WIDTH(W), .DEPTH(D), .ZERO_REG(Z)) dut (
    .clk(clk), .rst(rst),
    .read1RegSel(r1_sel), .read2RegSel(r2_sel), .writeRegSel(w_sel),
    .writeData(w_data), .writeEn(w_en), .clrReq(clr_req),
    .read1Data(r1_data), .read2Data(r2_data),
    .busy(busy), .clrDone(clr_done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < D; i++) m_reg[i] = '0;
    m_left = 0;
    m_done = 0;
  endfunction

  function automatic logic [W-1:0] m_read(input int sel);
    if (Z != 0 && sel == 0) return '0;
    if (w_en && m_left == 0 && sel == int'(w_sel)) return w_data;
    return m_reg[sel];
  endfunction

  function automatic void model_edge();
    if (m_left > 0) begin
      m_reg[D - m_left] = '0;
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else begin
      m_done = 0;
      if (w_en && !(Z != 0 && w_sel == '0)) m_reg[w_sel] = w_data;
      if (clr_req) m_left = D;
    end
  endfunction

  task automatic drive(input int s1, input int s2, input int ws,
                       input logic [W-1:0] wd, input bit we, input bit clr);
    exp_t e;
    r1_sel  = AW'(s1);
    r2_sel  = AW'(s2);
    w_sel   = AW'(ws);
    w_data  = wd;
    w_en    = we;
    clr_req = clr;
    e.r1   = m_read(s1);
    e.r2   = m_read(s2);
    e.busy = (m_left > 0);
    e.done = m_done;
    e.err  = we && (m_left > 0);
    e.idx  = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    cyc++;
    #1;
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (!v) model_reset();
  endtask

  task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, idx, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("read1", mon_e.idx, r1_data, mon_e.r1);
      chk("read2", mon_e.idx, r2_data, mon_e.r2);
      chk("busy", mon_e.idx, W'(busy), W'(mon_e.busy));
      chk("clr_done", mon_e.idx, W'(clr_done), W'(mon_e.done));
      chk("err", mon_e.idx, W'(err), W'(mon_e.err));
    end
  end

  task automatic fill();
    for (int k = 0; k < D; k++) drive(k, (k + D - 1) % D, k, 32'h1111 * k, 1'b1, 1'b0);
  endtask

  initial begin
    int s1, s2, ws, waited;
    bit we, clr;
    model_reset();
    @(posedge clk);
    #1;
    drive(0, 0, 0, '0, 1'b0, 1'b0);
    drive(5, 9, 0, '0, 1'b0, 1'b0);
    set_rst(1'b1);
    for (int i = 0; i < D; i++) drive(i, D - 1 - i, 0, '0, 1'b0, 1'b0);

    drive(3, 3, 3, 32'hBEEF, 1'b1, 1'b0);
    drive(3, 3, 0, '0, 1'b0, 1'b0);
    drive(0, 0, 0, 32'h1234, 1'b1, 1'b0);
    drive(0, 1, 1, 32'h1234, 1'b1, 1'b0);
    drive(1, 0, 0, '0, 1'b0, 1'b0);

    fill();
    drive(2, 3, 0, '0, 1'b0, 1'b1);
    for (int i = 0; i < D + 2; i++) begin
      if (i == 4) drive(5, 5, 5, 32'hAAAA, 1'b1, 1'b0);
      else drive(i % D, 3, 0, '0, 1'b0, 1'b0);
    end
    for (int i = 0; i < D; i++) drive(i, (i + 5) % D, 0, '0, 1'b0, 1'b0);

    fill();
    for (int i = 0; i < D + 4; i++) drive(i % D, (i + 7) % D, 0, '0, 1'b0, 1'b1);
    for (int i = 0; i < D + 2; i++) drive((i + 3) % D, i % D, 0, '0, 1'b0, 1'b0);

    fill();
    drive(1, 2, 0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(i + 6, 15, 0, '0, 1'b0, 1'b0);
    set_rst(1'b0);
    drive(15, 7, 0, '0, 1'b0, 1'b0);
    drive(3, 12, 0, '0, 1'b0, 1'b0);
    set_rst(1'b1);
    drive(15, 15, 15, 32'hDEADBEEF, 1'b1, 1'b0);
    drive(15, 14, 0, '0, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      ws  = int'($urandom_range(0, D - 1));
      s1  = ($urandom_range(0, 1) == 1) ? ws : int'($urandom_range(0, D - 1));
      s2  = ($urandom_range(0, 3) == 0) ? ws : int'($urandom_range(0, D - 1));
      we  = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 24) == 0);
      drive(s1, s2, ws, W'($urandom), we, clr);
    end
    drive(0, 1, 0, '0, 1'b0, 1'b0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 5) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_param.md
# regfile_bypass_param

Parametrised register file with write-to-read bypass and a hardware clear sequencer. It replaces the fixed 8x16b bypassing register file in the decode stage. It adds configurable width and depth, an optional hard-wired zero register, and a one-register-per-cycle clear sweep with busy/done status. A write and a read of the same register in the same cycle return the new data combinationally, so no stall is needed between writeback and decode.

## Interface
- WIDTH, 16, data width in bits (>=1)
- DEPTH, 8, number of registers; power of two, 2..64
- ADDR_W, $clog2(DEPTH), register select width; derived, never overridden
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- read1RegSel  input  ADDR_W  read port 1 register select
- read2RegSel  input  ADDR_W  read port 2 register select
- writeRegSel  input  ADDR_W  write register select
- writeData  input  WIDTH  write data
- writeEn  input  1  write enable
- clrReq  input  1  start a clear sweep (sampled when idle)
- read1Data  output  WIDTH  read port 1 data (combinational)
- read2Data  output  WIDTH  read port 2 data (combinational)
- busy  output  1  clear sweep in progress (registered)
- clrDone  output  1  one-cycle pulse after the last register is cleared (registered)
- err  output  1  error flag (combinational)

## Operation
- Storage: DEPTH x WIDTH flops. Reset (rst=0, asynchronous) clears all registers to 0, sets the FSM to IDLE, busy=0, clrDone=0.
- Write: when writeEn=1 and busy=0, reg[writeRegSel] <= writeData at the clock edge. The write is dropped if ZERO_REG=1 and writeRegSel=0.
- Read port N, checked in priority order:
  - ZERO_REG=1 and sel=0 -> 0.
  - writeEn=1, busy=0 and sel==writeRegSel -> writeData (bypass).
  - Otherwise -> reg[sel].
  - Both ports may bypass in the same cycle.
- Clear FSM, states IDLE and SWEEP, with an ADDR_W-bit pointer ptr:
  - IDLE: if clrReq=1, go to SWEEP with ptr=0 and busy=1. clrReq is ignored in SWEEP.
  - SWEEP: reg[ptr] <= 0 each cycle and ptr increments.
  - When ptr==DEPTH-1, that register is cleared, the FSM returns to IDLE, busy drops, and clrDone pulses high for exactly one cycle.
- While busy: writeEn is ignored (no storage update, no bypass), and reads return current stored contents. Registers not yet swept keep their old values.
- err = 1 when writeData or writeEn contains X/Z (simulation check, same as the current file), OR when writeEn=1 while busy=1.
- Address widths are exact (DEPTH is a power of two), so no out-of-range selects exist.

## Timing
- Read latency 0: outputs are combinational from the selects, storage, and the bypass path.
- Write-to-read through storage: visible on the cycle after the edge; visible in the same cycle through bypass.
- Clear sweep takes DEPTH cycles:
  - clrReq is high at edge E0, so busy=1 after E0.
  - reg[k] is zero after edge E0+1+k.
  - busy=0 and clrDone=1 after edge E0+DEPTH.
  - clrDone=0 after the following edge.
- clrReq held high across the end of a sweep starts a new sweep on the cycle after clrDone. The cycle in which clrDone=1 is IDLE and samples clrReq.
- Reset asserted mid-sweep clears everything immediately. No clrDone pulse follows.
- Reset release: the first writes take effect at the first rising edge with rst=1.

## Test plan
- Reset then read all registers on both ports -> all 0; busy=0, clrDone=0, err=0.
- Write 0xBEEF to r3; in the same cycle read1Sel=3, read2Sel=3 -> both 0xBEEF (bypass). Next cycle with writeEn=0 -> 0xBEEF from storage.
- ZERO_REG=1: write 0x1234 to r0; read r0 in the same cycle and the next -> 0x0000. Write r1=0x1234 -> r1 reads 0x1234.
- Fill r0..r7 with 0x1111*k, pulse clrReq:
  - busy is high for 8 cycles.
  - After 3 sweep edges, r2=0 and r3=0x3333.
  - clrDone is a single pulse and all registers read 0.
- Assert writeEn (r5, 0xAAAA) during a sweep -> err=1 that cycle, no bypass (read r5 shows the stored value), r5=0 after the sweep.
- Drop rst mid-sweep with WIDTH=32, DEPTH=16 -> all registers 0, busy=0 immediately. After release, a write of 0xDEADBEEF to r15 reads back correctly.
